// File: rtl/rtc_bcd_counter.sv
// ---------------------------------------------------------------------------
// rtc_bcd_counter
//
// Time-of-day counter in the clock_in domain. The divided slow_clk from the
// divider stage is synchronized and rising-edge detected. Each detected edge
// advances a BCD hh:mm:ss count by one second while run is high. The time can
// be loaded through a one-cycle valid / ack-or-err handshake. All outputs are
// registered and feed the display driver stage.
//
// Parameters
//   SYNC_STAGES  clock_in flops on slow_clk ahead of the edge detector (1..3)
//   HOUR_WRAP    decimal hour modulus; hours run 0..HOUR_WRAP-1 (2..24)
//
// Ports
//   clock_in     system clock, all logic on its rising edge
//   reset_n      asynchronous active-low reset
//   slow_clk     divided clock, treated as a level and sampled on clock_in
//   run          1 = count seconds, 0 = hold the count
//   load_valid   one-cycle load request
//   load_hh/mm/ss  BCD time to load
//   load_ack     one-cycle pulse, load accepted
//   load_err     one-cycle pulse, load rejected
//   hour_bcd/min_bcd/sec_bcd  current time, [7:4] tens, [3:0] units
//   tick_out     one-cycle pulse per counted second
//   day_roll     one-cycle pulse when the count wraps to 00:00:00
//   running      registered copy of run
// ---------------------------------------------------------------------------
module rtc_bcd_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int HOUR_WRAP   = 24
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       slow_clk,
  input  logic       run,
  input  logic       load_valid,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic       load_ack,
  output logic       load_err,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       tick_out,
  output logic       day_roll,
  output logic       running
);

  // Highest hour value and the exclusive load limit, both in BCD.
  localparam logic [7:0] HOUR_MAX   = {4'((HOUR_WRAP - 1) / 10), 4'((HOUR_WRAP - 1) % 10)};
  localparam logic [7:0] HOUR_LIMIT = {4'(HOUR_WRAP / 10), 4'(HOUR_WRAP % 10)};

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [7:0]             r_hour;
  logic [7:0]             r_min;
  logic [7:0]             r_sec;
  logic                   r_tick;
  logic                   r_roll;
  logic                   r_ack;
  logic                   r_err;
  logic                   r_running;

  logic w_edge;
  logic w_loadOk;
  logic w_doLoad;
  logic w_doTick;
  logic w_secWrap;
  logic w_minWrap;
  logic w_dayWrap;

  // Advance a two-digit BCD value by one, returning to 00 after maxv.
  function automatic logic [7:0] bcdInc(input logic [7:0] v, input logic [7:0] maxv);
    if (v == maxv)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Synchronizer and prev flop reset high so a slow_clk that is already high
  // when reset releases is not mistaken for a rising edge. The chain keeps
  // running regardless of run so no stale edge is left waiting.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync[0] <= slow_clk;
      for (int i = 1; i < SYNC_STAGES; i++)
        r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

  // Digit-wise BCD compares preserve numeric order once every nibble is <= 9.
  assign w_loadOk = (load_hh[7:4] <= 4'd9) && (load_hh[3:0] <= 4'd9) &&
                    (load_mm[7:4] <= 4'd9) && (load_mm[3:0] <= 4'd9) &&
                    (load_ss[7:4] <= 4'd9) && (load_ss[3:0] <= 4'd9) &&
                    (load_mm < 8'h60) && (load_ss < 8'h60) &&
                    (load_hh < HOUR_LIMIT);

  // An accepted load takes priority over a coincident tick; a rejected one
  // does not.
  assign w_doLoad = load_valid & w_loadOk;
  assign w_doTick = w_edge & run & ~w_doLoad;

  assign w_secWrap = (r_sec == 8'h59);
  assign w_minWrap = w_secWrap && (r_min == 8'h59);
  assign w_dayWrap = w_minWrap && (r_hour == HOUR_MAX);

  // Time registers plus the registered status pulses.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_hour    <= 8'h00;
      r_min     <= 8'h00;
      r_sec     <= 8'h00;
      r_tick    <= 1'b0;
      r_roll    <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_tick    <= w_doTick;
      r_roll    <= w_doTick & w_dayWrap;
      r_ack     <= w_doLoad;
      r_err     <= load_valid & ~w_loadOk;
      r_running <= run;
      if (w_doLoad) begin
        r_hour <= load_hh;
        r_min  <= load_mm;
        r_sec  <= load_ss;
      end else if (w_doTick) begin
        r_sec <= bcdInc(r_sec, 8'h59);
        if (w_secWrap)
          r_min <= bcdInc(r_min, 8'h59);
        if (w_minWrap)
          r_hour <= bcdInc(r_hour, HOUR_MAX);
      end
    end
  end

  assign hour_bcd = r_hour;
  assign min_bcd  = r_min;
  assign sec_bcd  = r_sec;
  assign tick_out = r_tick;
  assign day_roll = r_roll;
  assign load_ack = r_ack;
  assign load_err = r_err;
  assign running  = r_running;

endmodule

// File: tb/tb_rtc_bcd_counter.sv
// ---------------------------------------------------------------------------
// tb_rtc_bcd_counter
//
// Drives rtc_bcd_counter with directed sequences followed by a randomized run.
// The reference model holds the time as seconds since midnight and derives
// edges from a history of sampled slow_clk values.
// ---------------------------------------------------------------------------
module tb_rtc_bcd_counter;

  localparam int S   = 2;
  localparam int HW  = 24;
  localparam int DAY = HW * 3600;

  logic       clock_in = 1'b0;
  logic       reset_n;
  logic       slow_clk;
  logic       run;
  logic       load_valid;
  logic [7:0] load_hh;
  logic [7:0] load_mm;
  logic [7:0] load_ss;
  logic       load_ack;
  logic       load_err;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       tick_out;
  logic       day_roll;
  logic       running;

  int checks     = 0;
  int failures   = 0;
  int ticksSeen  = 0;
  int rollsSeen  = 0;

  int expSec;
  bit expTick, expRoll, expAck, expErr, expRunning;
  bit hist[$];

  rtc_bcd_counter #(.SYNC_STAGES(S), .HOUR_WRAP(HW)) dut (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .slow_clk   (slow_clk),
    .run        (run),
    .load_valid (load_valid),
    .load_hh    (load_hh),
    .load_mm    (load_mm),
    .load_ss    (load_ss),
    .load_ack   (load_ack),
    .load_err   (load_err),
    .hour_bcd   (hour_bcd),
    .min_bcd    (min_bcd),
    .sec_bcd    (sec_bcd),
    .tick_out   (tick_out),
    .day_roll   (day_roll),
    .running    (running)
  );

  always #5 clock_in = ~clock_in;

  function automatic logic [7:0] toBcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic int fromBcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit digitsOk(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  task automatic modelReset();
    expSec     = 0;
    expTick    = 0;
    expRoll    = 0;
    expAck     = 0;
    expErr     = 0;
    expRunning = 0;
    hist.delete();
    for (int i = 0; i <= S; i++) hist.push_back(1'b1);
  endtask

  // One clock_in rising edge of the reference model, using the inputs the
  // DUT sees at that edge.
  task automatic modelUpdate();
    bit edgeSeen, ok, doLoad, doTick;
    if (!reset_n) begin
      modelReset();
      return;
    end
    hist.push_back(slow_clk);
    if (hist.size() > S + 2) void'(hist.pop_front());
    edgeSeen = hist[hist.size() - 1 - S] && !hist[hist.size() - 2 - S];
    ok = digitsOk(load_hh) && digitsOk(load_mm) && digitsOk(load_ss) &&
         fromBcd(load_hh) < HW && fromBcd(load_mm) < 60 && fromBcd(load_ss) < 60;
    doLoad     = load_valid && ok;
    doTick     = edgeSeen && run && !doLoad;
    expAck     = doLoad;
    expErr     = load_valid && !ok;
    expTick    = doTick;
    expRoll    = 0;
    expRunning = run;
    if (doLoad) begin
      expSec = fromBcd(load_hh) * 3600 + fromBcd(load_mm) * 60 + fromBcd(load_ss);
    end else if (doTick) begin
      expRoll = (expSec == DAY - 1);
      expSec  = (expSec + 1) % DAY;
    end
  endtask

  task automatic cmp8(input string tag, input string field, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, obs, expv);
    end
  endtask

  task automatic cmp1(input string tag, input string field, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s.%s observed=%b expected=%b", tag, field, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag);
    cmp8(tag, "hour", hour_bcd, toBcd(expSec / 3600));
    cmp8(tag, "min",  min_bcd,  toBcd((expSec / 60) % 60));
    cmp8(tag, "sec",  sec_bcd,  toBcd(expSec % 60));
    cmp1(tag, "tick", tick_out, expTick);
    cmp1(tag, "roll", day_roll, expRoll);
    cmp1(tag, "ack",  load_ack, expAck);
    cmp1(tag, "err",  load_err, expErr);
    cmp1(tag, "running", running, expRunning);
  endtask

  // Called at a falling edge; drives inputs, runs one clock and checks.
  task automatic applyStimulus(input string tag, input logic sv, input logic rv, input logic lv,
                               input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
    slow_clk   = sv;
    run        = rv;
    load_valid = lv;
    load_hh    = hh;
    load_mm    = mm;
    load_ss    = ss;
    @(posedge clock_in);
    modelUpdate();
    #1;
    checkOutput(tag);
    if (tick_out === 1'b1) ticksSeen++;
    if (day_roll === 1'b1) rollsSeen++;
    @(negedge clock_in);
  endtask

  // Divider-like slow clock with a period of four clock_in cycles.
  task automatic slowEdges(input string tag, input int n, input logic rv);
    for (int k = 0; k < n; k++) begin
      applyStimulus(tag, 1'b1, rv, 1'b0, 8'h00, 8'h00, 8'h00);
      applyStimulus(tag, 1'b1, rv, 1'b0, 8'h00, 8'h00, 8'h00);
      applyStimulus(tag, 1'b0, rv, 1'b0, 8'h00, 8'h00, 8'h00);
      applyStimulus(tag, 1'b0, rv, 1'b0, 8'h00, 8'h00, 8'h00);
    end
  endtask

  task automatic doLoad(input string tag, input logic rv,
                        input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
    applyStimulus(tag, 1'b0, rv, 1'b1, hh, mm, ss);
    applyStimulus(tag, 1'b0, rv, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    reset_n    = 1'b1;
    slow_clk   = 1'b1;
    run        = 1'b0;
    load_valid = 1'b0;
    load_hh    = 8'h00;
    load_mm    = 8'h00;
    load_ss    = 8'h00;
    modelReset();

    // Asynchronous reset, observed before any clock edge.
    #1 reset_n = 1'b0;
    #2;
    checkOutput("reset_async");
    @(negedge clock_in);
    repeat (2) applyStimulus("reset_hold", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

    // slow_clk held high across reset release must not tick.
    reset_n   = 1'b1;
    ticksSeen = 0;
    repeat (10) applyStimulus("release_high", 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    cmp8("release_high", "ticks", 8'(ticksSeen), 8'd0);

    // Three divider edges.
    applyStimulus("div_low", 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    applyStimulus("div_low", 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    ticksSeen = 0;
    slowEdges("div3", 3, 1'b1);
    cmp8("div3", "ticks", 8'(ticksSeen), 8'd3);
    cmp8("div3", "sec_const", sec_bcd, 8'h03);

    // Day rollover.
    doLoad("load_2359", 1'b1, 8'h23, 8'h59, 8'h58);
    ticksSeen = 0;
    rollsSeen = 0;
    slowEdges("roll", 2, 1'b1);
    cmp8("roll", "ticks", 8'(ticksSeen), 8'd2);
    cmp8("roll", "rolls", 8'(rollsSeen), 8'd1);
    cmp8("roll", "hms_const", hour_bcd | min_bcd | sec_bcd, 8'h00);

    // Minute and seconds-tens carries.
    doLoad("load_0959", 1'b1, 8'h00, 8'h09, 8'h59);
    slowEdges("carry_min", 1, 1'b1);
    cmp8("carry_min", "min_const", min_bcd, 8'h10);
    cmp8("carry_min", "sec_const", sec_bcd, 8'h00);
    doLoad("load_0009", 1'b1, 8'h00, 8'h00, 8'h09);
    slowEdges("carry_sec", 1, 1'b1);
    cmp8("carry_sec", "sec_const", sec_bcd, 8'h10);

    // Rejected loads.
    doLoad("bad_ss", 1'b1, 8'h00, 8'h10, 8'h5A);
    cmp8("bad_ss", "sec_const", sec_bcd, 8'h10);
    doLoad("bad_hh", 1'b1, 8'h24, 8'h00, 8'h00);
    cmp8("bad_hh", "hour_const", hour_bcd, 8'h00);

    // Valid load coincident with an effective edge: load wins, no tick.
    applyStimulus("coinc", 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    applyStimulus("coinc", 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    applyStimulus("coinc", 1'b1, 1'b1, 1'b1, 8'h12, 8'h00, 8'h00);
    cmp1("coinc", "ack_const", load_ack, 1'b1);
    cmp1("coinc", "tick_const", tick_out, 1'b0);
    cmp8("coinc", "hour_const", hour_bcd, 8'h12);
    cmp8("coinc", "sec_const", sec_bcd, 8'h00);
    applyStimulus("coinc", 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    applyStimulus("coinc", 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);

    // Hold with run=0, then resume.
    slowEdges("hold", 5, 1'b0);
    cmp8("hold", "sec_const", sec_bcd, 8'h00);
    slowEdges("resume", 1, 1'b1);
    cmp8("resume", "sec_const", sec_bcd, 8'h01);

    // Reset mid-count clears outputs before the next clock edge.
    slowEdges("precount", 2, 1'b1);
    reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("reset_mid");
    cmp8("reset_mid", "sec_const", sec_bcd, 8'h00);
    @(negedge clock_in);
    repeat (2) applyStimulus("reset_mid_hold", 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    reset_n = 1'b1;

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      logic sv, rv, lv;
      sv = ($urandom_range(0, 2) == 0) ? ~slow_clk : slow_clk;
      rv = ($urandom_range(0, 7) == 0) ? ~run : run;
      lv = ($urandom_range(0, 9) == 0);
      applyStimulus("random", sv, rv, lv,
                    8'($urandom_range(0, 8'h2F)),
                    8'($urandom_range(0, 8'h6A)),
                    8'($urandom_range(0, 8'h6A)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
